// File: rtl/gd_quad_minimizer.sv
// Gradient-descent minimiser for y = (x - offset)^2 in signed Q(W-F).F fixed point.
// Runs one iteration per cycle until it converges or the budget runs out. Every
// W-bit intermediate saturates, and ovf records any clamp since the last INIT.
// Optional feature: define GD_ADAPTIVE_LR_EN to halve the learning rate on overshoot.
// When it is not defined, lr_cur stays constant after INIT.

module gd_quad_minimizer #(
    parameter int unsigned W      = 32,
    parameter int unsigned F      = 8,
    parameter int unsigned ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [W-1:0]      x_init,
    input  logic [W-1:0]      offset,
    input  logic [W-1:0]      lr,
    input  logic [W-1:0]      tol,
    input  logic [ITER_W-1:0] cfg_iters,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [W-1:0]      x_at_min,
    output logic [2*W-1:0]    y_min,
    output logic [ITER_W-1:0] iters_used,
    output logic [W-1:0]      lr_cur,
    output logic              ovf
);

    typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

    state_e              state_q;
    logic signed [W-1:0] x_q;
    logic [ITER_W-1:0]   iters_cfg_q;
`ifdef GD_ADAPTIVE_LR_EN
    logic [2*W-1:0]      y_prev_q;
    logic signed [W-1:0] lr_half;
    logic                overshoot;
`endif

    logic signed [W-1:0]   x_op, d, g, step, x_next, lr_eff;
    logic                  d_sat, g_sat, step_sat, x_sat;
    logic signed [2*W-1:0] sq, prod, prod_sh;
    logic [2*W-1:0]        y_val;
    logic signed [W:0]     g_abs, tol_ext;
    logic                  hit_tol, last_iter;
    logic [ITER_W-1:0]     iters_inc;

    // Sign-extend a W-bit value into the 2W+1-bit headroom used for saturation.
    function automatic logic signed [2*W:0] sext(input logic [W-1:0] v);
        sext = {{(W+1){v[W-1]}}, v};
    endfunction

    // Clamp to the signed W-bit range; the MSB of the result flags a clamp.
    function automatic logic [W:0] sat(input logic signed [2*W:0] v);
        logic signed [2*W:0] hi, lo;
        hi = {{(W+2){1'b0}}, {(W-1){1'b1}}};
        lo = {{(W+2){1'b1}}, {(W-1){1'b0}}};
        if (v > hi) begin
            sat = {1'b1, 1'b0, {(W-1){1'b1}}};
        end else if (v < lo) begin
            sat = {1'b1, 1'b1, {(W-1){1'b0}}};
        end else begin
            sat = {1'b0, v[W-1:0]};
        end
    endfunction

    // Iteration datapath: error, gradient, cost, step and next x.
    always_comb begin
        // In INIT the cost is evaluated on x_init to seed y_min.
        x_op = (state_q == StInit) ? x_init : x_q;
        {d_sat, d} = sat(sext(x_op) - sext(offset));
        {g_sat, g} = sat(sext(d) + sext(d));
        sq    = d * d;
        y_val = sq >>> F;

        g_abs   = g[W-1] ? -{g[W-1], g} : {g[W-1], g};
        tol_ext = {tol[W-1], tol};
        hit_tol = (g_abs <= tol_ext);

`ifdef GD_ADAPTIVE_LR_EN
        overshoot = (iters_used != '0) && (y_val > y_prev_q);
        lr_half   = $signed(lr_cur) >>> 1;
        if (lr_half < 1) begin
            lr_half = {{(W-1){1'b0}}, 1'b1};
        end
        lr_eff = overshoot ? lr_half : $signed(lr_cur);
`else
        lr_eff = $signed(lr_cur);
`endif

        prod    = lr_eff * g;
        prod_sh = prod >>> F;
        {step_sat, step}  = sat({prod_sh[2*W-1], prod_sh});
        {x_sat, x_next}   = sat(sext(x_q) - sext(step));

        iters_inc = iters_used + 1'b1;
        last_iter = (iters_inc == iters_cfg_q);
    end

    // Control FSM with all state and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            x_at_min    <= '0;
            y_min       <= '0;
            iters_used  <= '0;
            lr_cur      <= '0;
            ovf         <= 1'b0;
            x_q         <= '0;
            iters_cfg_q <= '0;
`ifdef GD_ADAPTIVE_LR_EN
            y_prev_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StInit;
                        busy    <= 1'b1;
                    end
                end
                StInit: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        x_q         <= x_init;
                        x_at_min    <= x_init;
                        y_min       <= y_val;
                        iters_used  <= '0;
                        converged   <= 1'b0;
                        ovf         <= 1'b0;
                        lr_cur      <= lr;
                        iters_cfg_q <= cfg_iters;
                        if (cfg_iters == '0) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        // Strict compare: on a tie the earlier x is kept.
                        if (y_val < y_min) begin
                            y_min    <= y_val;
                            x_at_min <= x_q;
                        end
                        iters_used <= iters_inc;
                        if (hit_tol) begin
                            converged <= 1'b1;
                            ovf       <= ovf | d_sat | g_sat;
                            state_q   <= StDone;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            x_q    <= x_next;
                            lr_cur <= lr_eff;
                            ovf    <= ovf | d_sat | g_sat | step_sat | x_sat;
`ifdef GD_ADAPTIVE_LR_EN
                            y_prev_q <= y_val;
`endif
                            if (last_iter) begin
                                state_q <= StDone;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    if (!start) begin
                        state_q <= StIdle;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gd_quad_minimizer.sv
// Self-checking bench for gd_quad_minimizer (W=32, F=8, ITER_W=8).
// Expected results are queued when a run is launched and compared when done rises.

module tb_gd_quad_minimizer;

    localparam int unsigned W      = 32;
    localparam int unsigned F      = 8;
    localparam int unsigned ITER_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort;
    logic [W-1:0]      x_init, offset, lr, tol;
    logic [ITER_W-1:0] cfg_iters;
    logic              busy, done, converged, ovf;
    logic [W-1:0]      x_at_min, lr_cur;
    logic [2*W-1:0]    y_min;
    logic [ITER_W-1:0] iters_used;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string             tag;
        logic              conv;
        logic [W-1:0]      xmin;
        logic [2*W-1:0]    ymin;
        logic [ITER_W-1:0] iters;
        logic [W-1:0]      lrc;
        logic              ovf;
        int                lat;
    } exp_t;

    exp_t sb[$];

    gd_quad_minimizer #(.W(W), .F(F), .ITER_W(ITER_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .x_init     (x_init),
        .offset     (offset),
        .lr         (lr),
        .tol        (tol),
        .cfg_iters  (cfg_iters),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .x_at_min   (x_at_min),
        .y_min      (y_min),
        .iters_used (iters_used),
        .lr_cur     (lr_cur),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Launch one run, wait (bounded) for done, then compare against the queued result.
    task automatic run_case(input exp_t e, input logic [W-1:0] xi, input logic [W-1:0] l,
                            input logic [W-1:0] t, input logic [ITER_W-1:0] it);
        exp_t got_e;
        int   lat;
        sb.push_back(e);
        x_init    = xi;
        lr        = l;
        tol       = t;
        cfg_iters = it;
        start     = 1'b1;
        step_clk(1);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 600) begin
            step_clk(1);
            lat++;
        end
        got_e = sb.pop_front();
        check_eq({got_e.tag, " done"},       {63'd0, done},       64'd1);
        check_eq({got_e.tag, " latency"},    64'(lat),            64'(got_e.lat));
        check_eq({got_e.tag, " converged"},  {63'd0, converged},  {63'd0, got_e.conv});
        check_eq({got_e.tag, " iters_used"}, 64'(iters_used),     64'(got_e.iters));
        check_eq({got_e.tag, " x_at_min"},   64'(x_at_min),       64'(got_e.xmin));
        check_eq({got_e.tag, " y_min"},      y_min,               got_e.ymin);
        check_eq({got_e.tag, " lr_cur"},     64'(lr_cur),         64'(got_e.lrc));
        check_eq({got_e.tag, " ovf"},        {63'd0, ovf},        {63'd0, got_e.ovf});
        step_clk(1);
        check_eq({got_e.tag, " done_clear"}, {63'd0, done},       64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " busy"},       {63'd0, busy},      64'd0);
        check_eq({tag, " done"},       {63'd0, done},      64'd0);
        check_eq({tag, " converged"},  {63'd0, converged}, 64'd0);
        check_eq({tag, " x_at_min"},   64'(x_at_min),      64'd0);
        check_eq({tag, " y_min"},      y_min,              64'd0);
        check_eq({tag, " iters_used"}, 64'(iters_used),    64'd0);
        check_eq({tag, " lr_cur"},     64'(lr_cur),        64'd0);
        check_eq({tag, " ovf"},        {63'd0, ovf},       64'd0);
    endtask

    initial begin
        exp_t              e;
        logic signed [63:0] dmax;
        int                 lat;

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        x_init    = '0;
        offset    = 32'h400;
        lr        = '0;
        tol       = '0;
        cfg_iters = '0;
        step_clk(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        step_clk(2);

        // Converges on the second iteration with lr=0.5.
        e = '{tag: "t1", conv: 1'b1, xmin: 32'h400, ymin: 64'h0, iters: 8'd2,
              lrc: 32'h80, ovf: 1'b0, lat: 4};
        run_case(e, 32'h0, 32'h80, 32'h0, 8'd16);

        // Budget-limited run with lr=0.25.
        e = '{tag: "t2", conv: 1'b0, xmin: 32'h300, ymin: 64'h100, iters: 8'd3,
              lrc: 32'h40, ovf: 1'b0, lat: 5};
        run_case(e, 32'h0, 32'h40, 32'h0, 8'd3);

        // Extreme operands force saturation of the error term.
        offset = 32'h8000_0000;
        dmax   = 64'sh7FFF_FFFF;
        e = '{tag: "t3", conv: 1'b0, xmin: 32'h7FFF_FFFF, ymin: 64'((dmax * dmax) >>> F),
              iters: 8'd1, lrc: 32'h80, ovf: 1'b1, lat: 3};
        run_case(e, 32'h7FFF_FFFF, 32'h80, 32'h0, 8'd1);
        offset = 32'h400;

        // Oversized rate: oscillates without adaptation, settles with it.
`ifdef GD_ADAPTIVE_LR_EN
        e = '{tag: "t4", conv: 1'b0, xmin: 32'h600, ymin: 64'h400, iters: 8'd4,
              lrc: 32'hC0, ovf: 1'b0, lat: 6};
`else
        e = '{tag: "t4", conv: 1'b0, xmin: 32'h0, ymin: 64'h1000, iters: 8'd4,
              lrc: 32'h180, ovf: 1'b0, lat: 6};
`endif
        run_case(e, 32'h0, 32'h180, 32'h0, 8'd4);

        // Zero budget goes straight from INIT to DONE.
        e = '{tag: "t6", conv: 1'b0, xmin: 32'h200, ymin: 64'h400, iters: 8'd0,
              lrc: 32'h40, ovf: 1'b0, lat: 2};
        run_case(e, 32'h200, 32'h40, 32'h0, 8'd0);

        // Abort during the second RUN cycle.
        x_init    = 32'h0;
        lr        = 32'h40;
        tol       = 32'h0;
        cfg_iters = 8'd16;
        start     = 1'b1;
        step_clk(1);
        start = 1'b0;
        step_clk(2);
        abort = 1'b1;
        step_clk(1);
        abort = 1'b0;
        check_eq("abort busy",       {63'd0, busy},   64'd0);
        check_eq("abort done",       {63'd0, done},   64'd0);
        check_eq("abort iters_used", 64'(iters_used), 64'd1);
        check_eq("abort y_min",      y_min,           64'h1000);
        step_clk(3);
        check_eq("abort idle done",  {63'd0, done},   64'd0);
        check_eq("abort idle busy",  {63'd0, busy},   64'd0);

        // start held high through DONE must not restart the engine.
        x_init    = 32'h0;
        lr        = 32'h80;
        cfg_iters = 8'd16;
        start     = 1'b1;
        lat       = 0;
        while (!done && lat < 600) begin
            step_clk(1);
            lat++;
        end
        check_eq("hold reached done", {63'd0, done}, 64'd1);
        step_clk(5);
        check_eq("hold done",       {63'd0, done},   64'd1);
        check_eq("hold busy",       {63'd0, busy},   64'd0);
        check_eq("hold iters_used", 64'(iters_used), 64'd2);
        start = 1'b0;
        step_clk(1);
        check_eq("hold release done", {63'd0, done}, 64'd0);

        // Asynchronous reset in the middle of a run.
        x_init    = 32'h200;
        lr        = 32'h40;
        cfg_iters = 8'd16;
        start     = 1'b1;
        step_clk(1);
        start = 1'b0;
        step_clk(2);
        check_eq("pre-reset busy",     {63'd0, busy}, 64'd1);
        check_eq("pre-reset x_at_min", 64'(x_at_min), 64'h200);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun reset");
        step_clk(1);
        rst_n = 1'b1;
        step_clk(2);
        check_eq("post-reset busy", {63'd0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
